// File: rtl/vending_display_ctrl_if.sv
// Bundle between the vending controller core and the display scan stage.
// master drives credit/events and observes the display; slave is the scan stage.
interface vending_display_ctrl_if;
  logic [2:0] credit;
  logic       sale_pulse;
  logic       err_pulse;
  logic [3:0] code;
  logic [3:0] dig_en;
  logic [1:0] msg_state;

  modport master (
    output credit, sale_pulse, err_pulse,
    input  code, dig_en, msg_state
  );

  modport slave (
    input  credit, sale_pulse, err_pulse,
    output code, dig_en, msg_state
  );
endinterface

// File: rtl/vending_display_ctrl.sv
// 4-digit multiplexed symbol-code generator for the vending display.
// Shows live credit, or holds a SALE / ERR message for HOLD_CYC cycles after an event.
module vending_display_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int HOLD_CYC = 100000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vending_display_ctrl_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HC_LOAD    = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_CREDIT = 2'b00,
    ST_SALE   = 2'b01,
    ST_ERR    = 2'b10
  } state_t;

  state_t          r_state, w_state_next;
  logic [HW-1:0]   r_hc, w_hc_next;
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [3:0]      r_code;
  logic [3:0]      r_dig_en;
  logic [3:0]      w_cr;
  logic [3:0]      w_msg [4];

  // State register plus hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CREDIT;
      r_hc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_hc    <= w_hc_next;
    end
  end

  // Events take priority over expiry so a retrigger at hc==0 never shows a credit gap
  always_comb begin
    w_state_next = r_state;
    w_hc_next    = r_hc;
    case (r_state)
      ST_CREDIT: begin
        if (bus.err_pulse) begin
          w_state_next = ST_ERR;
          w_hc_next    = HC_LOAD;
        end else if (bus.sale_pulse) begin
          w_state_next = ST_SALE;
          w_hc_next    = HC_LOAD;
        end
      end
      ST_SALE: begin
        if (bus.err_pulse) begin
          w_state_next = ST_ERR;
          w_hc_next    = HC_LOAD;
        end else if (bus.sale_pulse) begin
          w_hc_next    = HC_LOAD;
        end else if (r_hc == '0) begin
          w_state_next = ST_CREDIT;
        end else begin
          w_hc_next    = r_hc - 1'b1;
        end
      end
      ST_ERR: begin
        if (bus.err_pulse) begin
          w_hc_next    = HC_LOAD;
        end else if (r_hc == '0) begin
          w_state_next = ST_CREDIT;
        end else begin
          w_hc_next    = r_hc - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_CREDIT;
        w_hc_next    = '0;
      end
    endcase
  end

  // Out-of-range credit is shown as 'E'
  assign w_cr = (bus.credit <= 3'd5) ? {1'b0, bus.credit} : 4'h7;

  always_comb begin
    w_msg[0] = 4'hF;
    w_msg[1] = 4'hF;
    w_msg[2] = 4'hF;
    w_msg[3] = 4'hF;
    case (r_state)
      ST_CREDIT: begin
        w_msg[0] = w_cr;
        w_msg[1] = 4'h6;
      end
      ST_SALE: begin
        w_msg[1] = 4'h9;
        w_msg[2] = 4'h8;
        w_msg[3] = 4'hA;
      end
      ST_ERR: begin
        w_msg[0] = w_cr;
        w_msg[3] = 4'h7;
      end
      default: ;
    endcase
  end

  // Free-running scan, independent of the message FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_idx    <= 2'd0;
      r_code   <= 4'hF;
      r_dig_en <= 4'b0000;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_code   <= w_msg[r_idx];
      r_dig_en <= 4'b0001 << r_idx;
    end
  end

  assign bus.code      = r_code;
  assign bus.dig_en    = r_dig_en;
  assign bus.msg_state = r_state;

endmodule

// File: tb/tb_vending_display_ctrl.sv
// Randomized bench for vending_display_ctrl against a per-cycle behavioural model.
module tb_vending_display_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int HOLD_CYC = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vending_display_ctrl_if bus ();

  vending_display_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: 0=CREDIT 1=SALE 2=ERR, visible cycles remaining, edges since release
  int m_state = 0;
  int m_rem   = 0;
  int m_k     = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] msg_digit(input int st, input logic [2:0] cr, input int d);
    logic [3:0] m [4];
    logic [3:0] c;
    c = (cr > 3'd5) ? 4'h7 : {1'b0, cr};
    m[0] = 4'hF; m[1] = 4'hF; m[2] = 4'hF; m[3] = 4'hF;
    if (st == 0) begin
      m[0] = c; m[1] = 4'h6;
    end else if (st == 1) begin
      m[1] = 4'h9; m[2] = 4'h8; m[3] = 4'hA;
    end else begin
      m[0] = c; m[3] = 4'h7;
    end
    return m[d];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_code"},  32'(bus.code),      32'hF);
    chk_eq({tag, "_dig"},   32'(bus.dig_en),    32'h0);
    chk_eq({tag, "_state"}, 32'(bus.msg_state), 32'h0);
  endtask

  task automatic cycle(input logic [2:0] cr, input logic s, input logic e);
    int d;
    logic [3:0] exp_code;
    logic [3:0] exp_dig;
    @(negedge clk);
    bus.credit     = cr;
    bus.sale_pulse = s;
    bus.err_pulse  = e;
    d        = (m_k / SCAN_DIV) % 4;
    exp_code = msg_digit(m_state, cr, d);
    exp_dig  = 4'(1 << d);
    if (e) begin
      m_state = 2; m_rem = HOLD_CYC;
    end else if (s && m_state != 2) begin
      m_state = 1; m_rem = HOLD_CYC;
    end else if (m_state != 0) begin
      m_rem--;
      if (m_rem == 0) m_state = 0;
    end
    m_k++;
    @(posedge clk);
    #1;
    chk_eq("code",      32'(bus.code),      32'(exp_code));
    chk_eq("dig_en",    32'(bus.dig_en),    32'(exp_dig));
    chk_eq("msg_state", 32'(bus.msg_state), 32'(m_state));
  endtask

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_k = 0;
  endtask

  // Fire one event, then count how many cycles the resulting state is shown
  task automatic dwell(input string tag, input logic s, input logic e,
                       input int pre_idle, input int want_state);
    int cnt;
    for (int i = 0; i < pre_idle; i++) cycle(3'd2, 1'b0, 1'b0);
    cycle(3'd2, s, e);
    cnt = (32'(bus.msg_state) == want_state) ? 1 : 0;
    for (int i = 0; i < 2 * HOLD_CYC; i++) begin
      cycle(3'd2, 1'b0, 1'b0);
      if (32'(bus.msg_state) == want_state) cnt++;
    end
    chk_eq(tag, 32'(cnt), 32'(HOLD_CYC));
  endtask

  initial begin
    bus.credit     = 3'd3;
    bus.sale_pulse = 1'b0;
    bus.err_pulse  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset_vals("rst");
    end
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 16; i++) cycle(3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(3'd7, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(3'd5, 1'b0, 1'b0);

    dwell("sale_dwell", 1'b1, 1'b0, 0, 1);
    cycle(3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) cycle(3'd4, 1'b0, 1'b0);

    // ERR: sale at hc=5 ignored, then err at hc=5 gives a full new hold
    cycle(3'd1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) cycle(3'd1, 1'b0, 1'b0);
    cycle(3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(3'd1, 1'b0, 1'b0);
    cycle(3'd1, 1'b0, 1'b1);
    dwell("err_dwell", 1'b0, 1'b1, 14, 2);

    // async reset mid-SALE
    cycle(3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(3'd3, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("async_hold");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) cycle(3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 800; i++) begin
      cycle(3'($urandom_range(0, 7)),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
